reg_operand_reader: RTL and testbench
=====================================

# reg_operand_reader

Operand-fetch stage that sits between decode and execute and is the read-side partner of the 32×32 register file. Accepts decoded source/destination fields over a valid/ready handshake, drives the register file read addresses, and captures both operands into an output pipeline register. A 32-entry busy scoreboard tracks destinations still in flight and stalls read-after-write hazards until the matching writeback arrives.

## Interface
- Parameters: none (XLEN fixed at 32, 32 architectural registers, x0 hard-wired zero).
- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — one clock; reset is asynchronous and active-low.
- `in_valid` in 1 — decoded instruction present.
- `in_ready` out 1 — stage accepts this cycle.
- `in_rs1`, `in_rs2` in 5 — source register indices.
- `in_use1`, `in_use2` in 1 — source actually read (unused source never stalls).
- `in_rd` in 5 — destination index.
- `in_we` in 1 — instruction writes `in_rd`.
- `A1`, `A2` out 5 — register file read addresses; combinational copies of `in_rs1`/`in_rs2`.
- `RD1`, `RD2` in 32 — register file read data.
- `wb_we` in 1, `wb_rd` in 5, `wb_data` in 32 — writeback snoop (same values the register file writes).
- `flush` in 1 — drop instruction held in output register.
- `out_valid` out 1, `out_ready` in 1 — output handshake to execute.
- `out_rs1_val`, `out_rs2_val` out 32 — captured operands.
- `out_rd` out 5, `out_we` out 1 — forwarded destination fields.
- `stall_count` out 16 — saturating count of hazard-stall cycles.

## Operation
- Scoreboard `busy[31:0]`; `busy[0]` always 0.
- `hazard = in_valid & ((in_use1 & busy[in_rs1] & in_rs1!=0) | (in_use2 & busy[in_rs2] & in_rs2!=0))`, after bypass qualification (see Configuration).
- `in_ready = !hazard & !flush & (!out_valid | out_ready)`.
- Accept (`in_valid & in_ready`): capture RD1/RD2 (or bypass value), `in_rd`, `in_we`; set `busy[in_rd]` if `in_we & in_rd!=0`.
- Source index 0 always yields operand 0 regardless of RD1/RD2.
- Writeback with `wb_we & wb_rd!=0`: clear `busy[wb_rd]`. Same-cycle set and clear of same index: set wins.
- Output register: holds while `out_valid & !out_ready`; cleared on consume with no new accept.
- `flush`: next cycle `out_valid=0`; if held instruction had `out_we & out_rd!=0`, clear `busy[out_rd]` (its writeback will never come). No accept in a flush cycle.
- `stall_count` increments each cycle `hazard` is 1; saturates at 16'hFFFF; only reset clears it.

## Timing
- Reset (rst=0, async): `out_valid=0`, `out_rs1_val=out_rs2_val=0`, `out_rd=0`, `out_we=0`, `busy=0`, `stall_count=0`. `in_ready` reflects the combinational equation (1 when `flush=0`, no hazard).
- Latency: accept in cycle N → `out_valid=1` with operands in cycle N+1.
- Full throughput: back-to-back accepts when `out_ready=1` and no hazard.
- Backpressure: `out_valid=1 & out_ready=0` → `in_ready=0`; output stable.
- Register file updates on the falling edge, so a writeback in cycle N is visible on RD1/RD2 from the second half of cycle N; hazard stall releases the cycle after `busy` clears.
- Reset asserted mid-stall or mid-handshake: all state cleared immediately; in-flight instruction lost.

## Configuration
- `OPREAD_WB_BYPASS_EN` defined: a busy source whose index equals `wb_rd` with `wb_we=1` in the same cycle is not a hazard; operand taken from `wb_data`. Bypass has priority over RD.
- Undefined: that cycle still stalls; instruction accepted next cycle reading RD from the register file. No bypass mux synthesized.

## Test plan
- Reset release, accept rs1=3, rs2=4 with RD1=0x11, RD2=0x22 → next cycle `out_valid=1`, operands 0x11/0x22, `stall_count=0`.
- Accept rd=5 we=1, then rs1=5 use1=1 → `in_ready=0`, `stall_count` increments each cycle until `wb_we=1 wb_rd=5 wb_data=0xABCD`; with `OPREAD_WB_BYPASS_EN` accepted that cycle with operand 0xABCD, without it accepted one cycle later with RD1 value.
- rs1=0 use1=1 with RD1=0xFFFFFFFF, rd=0 we=1 → operand 0, no busy bit set, no stall on later reads of x0.
- `out_ready=0` for 3 cycles with new `in_valid` → `in_ready=0`, output stable 3 cycles, then advances one per cycle.
- Held instruction rd=7 we=1, assert `flush` → `out_valid=0` next cycle, `busy[7]=0`, following read of x7 not stalled.
- Force 70000 hazard cycles → `stall_count` saturates at 0xFFFF; drive rst=0 mid-stall → all outputs and `busy` zero immediately.

Source files
------------

// File: rtl/reg_operand_reader.sv
// reg_operand_reader: operand-fetch stage between decode and execute.
//
// Takes decoded source/destination fields over a valid/ready handshake. It drives
// the register file read addresses and captures both operands into an output
// pipeline register. A 32-entry busy scoreboard marks destinations that are still
// in flight. Read-after-write hazards stall until the matching writeback arrives.
//
// Optional feature: define OPREAD_WB_BYPASS_EN to take a busy source straight from
// the writeback bus in the cycle it is written, instead of stalling that cycle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake from decode
//   in_rs1/in_rs2, in_use1/2  source indices and their use flags
//   in_rd, in_we              destination index and write enable
//   A1, A2                    register file read addresses (combinational)
//   RD1, RD2                  register file read data
//   wb_we, wb_rd, wb_data     writeback snoop
//   flush                     drop the instruction held in the output register
//   out_valid/out_ready       output handshake to execute
//   out_rs1_val/out_rs2_val   captured operands
//   out_rd, out_we            forwarded destination fields
//   stall_count               saturating count of hazard-stall cycles
module reg_operand_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic        in_use1,
    input  logic        in_use2,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    output logic [4:0]  A1,
    output logic [4:0]  A2,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [15:0] stall_count
);

    logic [31:0] busy_q, busy_d;
    logic        out_valid_q;
    logic [31:0] out_rs1_q, out_rs2_q;
    logic [4:0]  out_rd_q;
    logic        out_we_q;
    logic [15:0] stall_q;

    logic        hz1, hz2, hazard, accept;
    logic [31:0] op1, op2;

    assign A1 = in_rs1;
    assign A2 = in_rs2;

`ifdef OPREAD_WB_BYPASS_EN
    logic byp1, byp2;
    // A source is never x0 when it can hit here, so wb_rd != 0 is implied.
    assign byp1 = wb_we && (wb_rd == in_rs1);
    assign byp2 = wb_we && (wb_rd == in_rs2);
    assign hz1  = in_use1 && (in_rs1 != 5'd0) && busy_q[in_rs1] && !byp1;
    assign hz2  = in_use2 && (in_rs2 != 5'd0) && busy_q[in_rs2] && !byp2;
    assign op1  = (in_rs1 == 5'd0) ? 32'd0 : (byp1 ? wb_data : RD1);
    assign op2  = (in_rs2 == 5'd0) ? 32'd0 : (byp2 ? wb_data : RD2);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign hz1 = in_use1 && (in_rs1 != 5'd0) && busy_q[in_rs1];
    assign hz2 = in_use2 && (in_rs2 != 5'd0) && busy_q[in_rs2];
    assign op1 = (in_rs1 == 5'd0) ? 32'd0 : RD1;
    assign op2 = (in_rs2 == 5'd0) ? 32'd0 : RD2;
`endif

    assign hazard   = in_valid && (hz1 || hz2);
    assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Clears first, then the set, so a same-cycle set of the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_we && (wb_rd != 5'd0)) busy_d[wb_rd] = 1'b0;
        // A flushed writer never reaches writeback, so release its destination.
        if (flush && out_valid_q && out_we_q && (out_rd_q != 5'd0)) busy_d[out_rd_q] = 1'b0;
        if (accept && in_we && (in_rd != 5'd0)) busy_d[in_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= 32'd0;
            out_valid_q <= 1'b0;
            out_rs1_q   <= 32'd0;
            out_rs2_q   <= 32'd0;
            out_rd_q    <= 5'd0;
            out_we_q    <= 1'b0;
            stall_q     <= 16'd0;
        end else begin
            busy_q <= busy_d;
            if (hazard && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
            if (flush) begin
                out_valid_q <= 1'b0;
                out_rs1_q   <= 32'd0;
                out_rs2_q   <= 32'd0;
                out_rd_q    <= 5'd0;
                out_we_q    <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_rs1_q   <= op1;
                out_rs2_q   <= op2;
                out_rd_q    <= in_rd;
                out_we_q    <= in_we;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_rs1_q   <= 32'd0;
                out_rs2_q   <= 32'd0;
                out_rd_q    <= 5'd0;
                out_we_q    <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rs1_val = out_rs1_q;
    assign out_rs2_val = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_we      = out_we_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_reg_operand_reader.sv
module tb_reg_operand_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use1, in_use2, in_we;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [4:0]  rd;
        logic        we;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_operand_reader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
        .in_rd(in_rd), .in_we(in_we),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_we(out_we),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait until mid-cycle, before the falling edge, to sample combinational outputs.
    task automatic mid();
        #3;
    endtask

    task automatic push(input logic [31:0] v1, input logic [31:0] v2,
                        input logic [4:0] rd, input logic we);
        exp_t e;
        e.v1 = v1; e.v2 = v2; e.rd = rd; e.we = we;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_rs1"}, out_rs1_val, e.v1);
            chk({tag, "_rs2"}, out_rs2_val, e.v2);
            chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, e.rd});
            chk({tag, "_we"}, {31'd0, out_we}, {31'd0, e.we});
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic we);
        in_valid = 1'b1;
        in_rs1 = rs1; in_use1 = u1; RD1 = d1;
        in_rs2 = rs2; in_use2 = u2; RD2 = d2;
        in_rd = rd; in_we = we;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_use1 = 0; in_use2 = 0;
        in_rd = 0; in_we = 0; RD1 = 0; RD2 = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
        #2;
        // Reset state, before any clock edge.
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rs1", out_rs1_val, 32'd0);
        chk("rst_rs2", out_rs2_val, 32'd0);
        chk("rst_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_we", {31'd0, out_we}, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        rst = 1'b1;
        cyc();

        // Basic accept, one-cycle latency.
        drive(5'd3, 1, 32'h11, 5'd4, 1, 32'h22, 5'd1, 0);
        mid();
        chk("basic_ready", {31'd0, in_ready}, 32'd1);
        chk("basic_A1", {27'd0, A1}, 32'd3);
        chk("basic_A2", {27'd0, A2}, 32'd4);
        push(32'h11, 32'h22, 5'd1, 0);
        cyc();
        in_valid = 0;
        pop_check("basic");
        chk("basic_stall", {16'd0, stall_count}, 32'd0);
        cyc();
        chk("basic_drain", {31'd0, out_valid}, 32'd0);

        // RAW hazard on x5.
        drive(5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd5, 1);
        push(32'h1, 32'h2, 5'd5, 1);
        cyc();
        drive(5'd5, 1, 32'h55, 5'd0, 0, 32'h0, 5'd6, 0);
        pop_check("raw_prod");
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("raw_stall_ready", {31'd0, in_ready}, 32'd0);
            cyc();
            exp_stall++;
            chk("raw_stall_cnt", {16'd0, stall_count}, exp_stall);
        end
        wb_we = 1; wb_rd = 5'd5; wb_data = 32'hABCD;
`ifdef OPREAD_WB_BYPASS_EN
        mid();
        chk("byp_ready", {31'd0, in_ready}, 32'd1);
        push(32'hABCD, 32'h0, 5'd6, 0);
        cyc();
        wb_we = 0;
        in_valid = 0;
        pop_check("byp_out");
`else
        mid();
        chk("wb_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        exp_stall++;
        wb_we = 0;
        RD1 = 32'hABCD;
        mid();
        chk("post_wb_ready", {31'd0, in_ready}, 32'd1);
        push(32'hABCD, 32'h0, 5'd6, 0);
        cyc();
        in_valid = 0;
        pop_check("post_wb_out");
`endif
        chk("raw_stall_final", {16'd0, stall_count}, exp_stall);
        cyc();

        // x0 sources read as zero; x0 destination never becomes busy.
        drive(5'd0, 1, 32'hFFFFFFFF, 5'd0, 1, 32'hFFFFFFFF, 5'd0, 1);
        push(32'h0, 32'h0, 5'd0, 1);
        cyc();
        pop_check("x0_first");
        mid();
        chk("x0_no_stall", {31'd0, in_ready}, 32'd1);
        push(32'h0, 32'h0, 5'd0, 1);
        cyc();
        in_valid = 0;
        pop_check("x0_second");
        chk("x0_stall", {16'd0, stall_count}, exp_stall);
        cyc();

        // Backpressure for three cycles, then one result per cycle.
        out_ready = 0;
        drive(5'd8, 1, 32'h100, 5'd9, 1, 32'h200, 5'd10, 0);
        push(32'h100, 32'h200, 5'd10, 0);
        cyc();
        drive(5'd11, 1, 32'h300, 5'd12, 1, 32'h400, 5'd12, 0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_rs1", out_rs1_val, sb[0].v1);
            chk("bp_hold_rs2", out_rs2_val, sb[0].v2);
            cyc();
        end
        out_ready = 1;
        pop_check("bp_a");
        mid();
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        push(32'h300, 32'h400, 5'd12, 0);
        cyc();
        pop_check("bp_b");
        drive(5'd13, 1, 32'h500, 5'd14, 1, 32'h600, 5'd15, 0);
        push(32'h500, 32'h600, 5'd15, 0);
        cyc();
        in_valid = 0;
        pop_check("bp_c");
        cyc();

        // Flush a held writer of x7; x7 must then be readable without a stall.
        out_ready = 0;
        drive(5'd1, 1, 32'h7, 5'd2, 1, 32'h8, 5'd7, 1);
        push(32'h7, 32'h8, 5'd7, 1);
        cyc();
        in_valid = 0;
        pop_check("fl_held");
        flush = 1;
        mid();
        chk("fl_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        flush = 0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1;
        drive(5'd7, 1, 32'h77, 5'd0, 0, 32'h0, 5'd16, 0);
        mid();
        chk("fl_x7_ready", {31'd0, in_ready}, 32'd1);
        push(32'h77, 32'h0, 5'd16, 0);
        cyc();
        in_valid = 0;
        pop_check("fl_x7");
        chk("fl_stall", {16'd0, stall_count}, exp_stall);

        // Saturate the stall counter, then reset mid-stall.
        drive(5'd1, 1, 32'h9, 5'd2, 1, 32'h9, 5'd9, 1);
        push(32'h9, 32'h9, 5'd9, 1);
        cyc();
        drive(5'd9, 1, 32'h99, 5'd0, 0, 32'h0, 5'd17, 0);
        pop_check("sat_prod");
        repeat (70000) cyc();
        chk("sat_cnt", {16'd0, stall_count}, 32'h0000FFFF);
        chk("sat_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_rs1", out_rs1_val, 32'd0);
        chk("arst_rd", {27'd0, out_rd}, 32'd0);
        chk("arst_we", {31'd0, out_we}, 32'd0);
        chk("arst_stall", {16'd0, stall_count}, 32'd0);
        // busy[9] cleared: the pending read of x9 is no longer a hazard.
        chk("arst_busy_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        rst = 1;
        cyc();
        mid();
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        push(32'h99, 32'h0, 5'd17, 0);
        cyc();
        in_valid = 0;
        pop_check("post_rst_out");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
